// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {instr, pc} entries; a synchronous flush overrides push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_data,
    output fetch_entry_t               rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word fetches, buffers responses, handles redirects.
// Optional macro FETCH_PERF_CNT_EN adds the perf_stall_cnt output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int            CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   target_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;
    logic          stale;
    logic          granted;
    logic          launch;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign granted   = imem_req && imem_gnt;
    assign target_pc = redirect_pc & ~32'h3;

    // Credit uses registered occupancy only; a pop this cycle frees space next cycle.
    assign launch = !imem_req && !redirect_valid &&
                    (int'(fifo_count) + int'(outstanding) < FIFO_DEPTH);

    assign push = imem_rvalid && !redirect_valid && (discard_cnt == '0);
    assign pop  = out_valid && out_ready;

    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = resp_pc;

    always_comb begin
        outstanding_nxt = outstanding;
        if (granted && !imem_rvalid)
            outstanding_nxt = outstanding + ONE;
        else if (!granted && imem_rvalid)
            outstanding_nxt = outstanding - ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            stale       <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;

            if (launch) begin
                imem_req  <= 1'b1;
                imem_addr <= fetch_pc;
            end else if (granted) begin
                imem_req  <= 1'b0;
            end

            if (redirect_valid) begin
                fetch_pc    <= target_pc;
                resp_pc     <= target_pc;
                discard_cnt <= outstanding_nxt;
                stale       <= imem_req && !imem_gnt;
            end else begin
                // A stale grant fetches from the old stream: its word is owed to discard.
                if (granted && !stale)
                    fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
                if (granted)
                    stale <= 1'b0;
                if (push)
                    resp_pc <= resp_pc + 32'(INSTR_BYTES);
                discard_cnt <= discard_cnt + CW'(granted && stale)
                                           - CW'(imem_rvalid && (discard_cnt != '0));
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (push_entry),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign out_valid = (fifo_count != '0) && !redirect_valid;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stall_cnt <= '0;
        else if (out_ready && !out_valid && !redirect_valid && (perf_stall_cnt != '1))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized memory/decode traffic.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          inflight = 0;
    int          gnt_pct, rv_pct, max_extra;
    bit          gnt_hold, rv_hold, const13, rdy;
    bit          redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic [31:0] exp_pc;
    logic [31:0] rq_addr [$];
    int          rq_due [$];
    logic [31:0] gaddr [$];
    int          first_gnt, first_vld;
    bit          popped;
    logic [31:0] pop_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Memory contents: a fixed scramble of the word address, so data proves which address was read.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (const13)
            return 32'h0000_0013;
        return (a ^ 32'h3C5A_96E1) + {a[15:0], a[31:16]};
    endfunction

    task automatic set_knobs(input int gp, input int rp, input int ex);
        gnt_pct = gp; rv_pct = rp; max_extra = ex;
        gnt_hold = 1'b0; rv_hold = 1'b0; const13 = 1'b0; rdy = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_addr", imem_addr, RESET_PC);
        rq_addr.delete(); rq_due.delete(); gaddr.delete();
        inflight = 0; exp_pc = RESET_PC; first_gnt = -1; first_vld = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_req", {31'b0, imem_req}, 1);
        chk("first_addr", imem_addr, RESET_PC);
    endtask

    // One clock: drive inputs at negedge, check and update the reference, then cross posedge.
    task automatic cycle();
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        redir          = 1'b0;
        imem_gnt       = imem_req && !gnt_hold && ($urandom_range(0, 99) < gnt_pct);
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (rq_addr.size() > 0 && !rv_hold && rq_due[0] <= cyc &&
            $urandom_range(0, 99) < rv_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rq_addr.pop_front());
            void'(rq_due.pop_front());
            inflight--;
        end
        #1;
        popped = 1'b0;
        if (imem_req && imem_gnt) begin
            gaddr.push_back(imem_addr);
            rq_addr.push_back(imem_addr);
            rq_due.push_back(cyc + 1 + int'($urandom_range(0, max_extra)));
            inflight++;
            if (first_gnt < 0) first_gnt = cyc;
            chk("credit", 32'(inflight <= FIFO_DEPTH), 1);
        end
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (redirect_valid)
            chk("valid_in_redirect", {31'b0, out_valid}, 0);
        if (out_valid && out_ready) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_instr", out_instr, mem_word(out_pc));
            exp_pc = exp_pc + 32'd4;
            popped = 1'b1;
            pop_pc = out_pc;
        end
        if (redirect_valid)
            exp_pc = redirect_pc & ~32'h3;
        @(posedge clk);
        cyc++;
    endtask

    task automatic wait_pop(input string tag, input logic [31:0] want);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!popped && n < 200);
        if (!popped)
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        else
            chk(tag, pop_pc, want);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;

        // Streaming with immediate grants and next-cycle responses
        set_knobs(100, 100, 0);
        const13 = 1'b1;
        do_reset();
        repeat (20) cycle();
        chk("latency", 32'(first_vld - first_gnt), 32'd2);
        chk("stream_progress", 32'(exp_pc >= 32'h20), 32'd1);

        // Decode stalled: credit limits fetches to the buffer depth
        set_knobs(100, 100, 0);
        do_reset();
        rdy = 1'b0;
        repeat (20) cycle();
        chk("stall_grants", 32'(gaddr.size()), 32'd2);
        chk("stall_req_low", {31'b0, imem_req}, 0);
        rdy = 1'b1;
        n = 0;
        while (gaddr.size() < 3 && n < 50) begin cycle(); n++; end
        chk("resume_addr", (gaddr.size() >= 3) ? gaddr[2] : 32'hDEAD_BEEF, 32'h8);

        // Redirect with two requests in flight
        set_knobs(100, 100, 0);
        do_reset();
        rv_hold = 1'b1;
        n = 0;
        while (gaddr.size() < 2 && n < 20) begin cycle(); n++; end
        chk("two_outstanding", 32'(gaddr.size()), 32'd2);
        redir = 1'b1; redir_pc = 32'h0000_0103;
        cycle();
        rv_hold = 1'b0;
        wait_pop("redirect_pc", 32'h0000_0100);
        chk("redirect_fetch_addr", (gaddr.size() >= 3) ? gaddr[2] : 32'hDEAD_BEEF, 32'h100);

        // Redirect while a request waits for grant
        set_knobs(100, 100, 1);
        do_reset();
        gnt_hold = 1'b1;
        cycle();
        redir = 1'b1; redir_pc = 32'h0000_0200;
        cycle();
        repeat (3) cycle();
        chk("stale_req_held", {31'b0, imem_req}, 1);
        chk("stale_addr_held", imem_addr, RESET_PC);
        gnt_hold = 1'b0;
        wait_pop("stale_next_pc", 32'h0000_0200);
        chk("stale_gnt_addr", (gaddr.size() >= 1) ? gaddr[0] : 32'hDEAD_BEEF, RESET_PC);
        chk("post_stale_addr", (gaddr.size() >= 2) ? gaddr[1] : 32'hDEAD_BEEF, 32'h200);

        // Address wrap at the top of memory
        set_knobs(100, 100, 0);
        do_reset();
        redir = 1'b1; redir_pc = 32'hFFFF_FFFE;
        wait_pop("wrap_top", 32'hFFFF_FFFC);
        wait_pop("wrap_zero", 32'h0000_0000);

        // Randomized traffic with a mid-stream reset
        set_knobs(70, 70, 2);
        do_reset();
        for (int i = 0; i < 2400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) begin
                redir    = 1'b1;
                redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
            end
            gnt_pct = int'($urandom_range(30, 100));
            cycle();
            if (i == 1200) begin
                do_reset();
                rdy = 1'b1;
                wait_pop("restart_pc", RESET_PC);
            end
        end

`ifdef FETCH_PERF_CNT_EN
        set_knobs(100, 100, 0);
        do_reset();
        gnt_hold = 1'b1;
        repeat (5) cycle();
        rdy = 1'b0;
        cycle();
        chk("perf_stall_cnt", perf_stall_cnt, 32'd5);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Generates sequential word-aligned fetch addresses and issues them on a req/gnt/rvalid instruction-memory port.
- Buffers returned words with their PC in a small FIFO and hands {instr, pc} to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing the FIFO and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2. It also bounds granted-but-unanswered requests.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- redirect_valid  input  1  one-cycle redirect pulse from execute.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch word address.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses arrive in order, at least 1 cycle after gnt.
- imem_rdata  input  32  response instruction word.
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts.
- out_instr  output  32  instruction word.
- out_pc  output  32  PC of out_instr.

Behaviour:
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, out_valid=0.
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; discard_cnt=0; stale=0.
- Request issue:
  - imem_req and imem_addr are registered.
  - A new request launches (imem_req rises next edge, imem_addr=fetch_pc) when imem_req=0 and fifo_count+outstanding < FIFO_DEPTH. The check uses registered values; a same-cycle pop is not credited.
  - Once asserted, imem_req and imem_addr hold until imem_gnt.
  - On req&gnt: imem_req drops for at least one cycle, outstanding++, fetch_pc+=4 (wraps 32'hFFFF_FFFC -> 0).
  - First imem_req is asserted at the first clk edge after rst_n deasserts.
- Response:
  - On rvalid: outstanding--.
  - If discard_cnt>0: drop the word and decrement discard_cnt.
  - Otherwise: push {rdata, resp_pc} into the FIFO, then resp_pc+=4.
  - Gnt and rvalid in the same cycle: outstanding is unchanged.
- Output:
  - out_valid = FIFO non-empty AND NOT redirect_valid.
  - out_instr/out_pc come from the FIFO head.
  - Pop on out_valid&out_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Push when full cannot occur because of the credit rule; assertion required.
- Latency: gnt in cycle N, rvalid in N+1 -> out_valid in N+2.
- Redirect (highest priority, single cycle):
  - FIFO flushed.
  - fetch_pc and resp_pc <= {redirect_pc[31:2],2'b00}.
  - discard_cnt <= outstanding after this cycle's gnt/rvalid updates. A word received in the redirect cycle is dropped.
  - Pending ungranted request: held unchanged and marked stale. Its gnt increments discard_cnt instead of advancing fetch_pc. A gnt in the redirect cycle itself counts into discard_cnt.
  - A back-to-back redirect overrides the previous target; discard accounting accumulates.
- Reset mid-operation: all state returns to reset values immediately. The memory side must also be reset, so no stale rvalid arrives.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output perf_stall_cnt (32).
  - Counts cycles with out_ready=1 and out_valid=0 and redirect_valid=0.
  - Reset to 0; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {logic [31:0] instr; logic [31:0] pc;}
  - localparam INSTR_BYTES=4.
  - RESET_PC default constant.
- Sub-module fetch_fifo:
  - Parameterised depth, element type fetch_entry_t.
  - Ports: push, pop, flush, count.
  - Behaviour: synchronous flush; flush overrides push and pop.

Test Plan:
- Reset release, memory grants immediately, rvalid next cycle, rdata=32'h0000_0013, out_ready=1 -> out_pc=0,4,8... in order; first out_valid 2 cycles after first gnt.
- out_ready=0 with FIFO_DEPTH=2 -> exactly 2 granted requests, imem_req stays 0 while full; set out_ready=1 -> fetching resumes at pc 8.
- Redirect to 32'h0000_0103 with 2 outstanding -> both responses dropped; next out_pc=32'h0000_0100; no out_valid during redirect cycle.
- imem_req pending with gnt withheld, redirect to 32'h200 -> imem_addr unchanged until gnt; that response discarded; next fetch address 32'h200.
- fetch_pc=32'hFFFF_FFFC -> following request address 32'h0000_0000.
- rst_n pulsed low mid-stream -> imem_req=0 and out_valid=0 immediately; restart fetches from RESET_PC. With FETCH_PERF_CNT_EN: 5 starved ready cycles -> perf_stall_cnt=5.
